tank_move_arbiter: RTL and testbench

//  Sequences grid moves for both tanks through one shared tile-map read port; sits between the

---
 rtl/tank_pkg.sv | 83 ++++++++
 rtl/tank_key_decode.sv | 35 +++
 rtl/tank_move_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_tank_move_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types, constants and tile helpers for the two-tank move arbiter.
package tank_pkg;

   localparam int unsigned MAP_W       = 20;
   localparam int unsigned MAP_H       = 15;
   localparam int unsigned TILE_SHIFT  = 5;
   localparam int unsigned MOVE_PERIOD = 8;

   localparam int unsigned TX_W   = 5;
   localparam int unsigned TY_W   = 4;
   localparam int unsigned ADDR_W = 9;
   localparam int unsigned PIX_W  = 10;
   localparam int unsigned CD_W   = 3;
   localparam int unsigned KEY_W  = 8;

   localparam int unsigned P1_TX = 1;
   localparam int unsigned P1_TY = 13;
   localparam int unsigned P2_TX = 18;
   localparam int unsigned P2_TY = 1;

   localparam logic [KEY_W-1:0] KEY1_UP    = 8'h1A;
   localparam logic [KEY_W-1:0] KEY1_DOWN  = 8'h16;
   localparam logic [KEY_W-1:0] KEY1_LEFT  = 8'h04;
   localparam logic [KEY_W-1:0] KEY1_RIGHT = 8'h07;
   localparam logic [KEY_W-1:0] KEY2_UP    = 8'h52;
   localparam logic [KEY_W-1:0] KEY2_DOWN  = 8'h51;
   localparam logic [KEY_W-1:0] KEY2_LEFT  = 8'h50;
   localparam logic [KEY_W-1:0] KEY2_RIGHT = 8'h4F;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   typedef struct packed {
      logic [TX_W-1:0] tx;
      logic [TY_W-1:0] ty;
   } tile_t;

   typedef struct packed {
      logic valid;
      dir_t dir;
   } move_req_t;

   typedef struct packed {
      logic  off;
      tile_t tile;
   } target_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_A   = 3'd1,
      S_CHK_A  = 3'd2,
      S_RD_B   = 3'd3,
      S_CHK_B  = 3'd4,
      S_COMMIT = 3'd5
   } state_t;

   localparam tile_t P1_START = '{tx: TX_W'(P1_TX), ty: TY_W'(P1_TY)};
   localparam tile_t P2_START = '{tx: TX_W'(P2_TX), ty: TY_W'(P2_TY)};

   // Neighbour tile; stepping off any edge wraps past the grid bound and is flagged off.
   function automatic target_t step_tile(input tile_t t, input dir_t d);
      target_t r;
      r.off  = 1'b0;
      r.tile = t;
      case (d)
         DIR_UP:    r.tile.ty = t.ty - TY_W'(1);
         DIR_DOWN:  r.tile.ty = t.ty + TY_W'(1);
         DIR_LEFT:  r.tile.tx = t.tx - TX_W'(1);
         default:   r.tile.tx = t.tx + TX_W'(1);
      endcase
      r.off = (r.tile.tx >= TX_W'(MAP_W)) || (r.tile.ty >= TY_W'(MAP_H));
      return r;
   endfunction

   function automatic logic [ADDR_W-1:0] tile_index(input tile_t t);
      return ADDR_W'(t.ty) * ADDR_W'(MAP_W) + ADDR_W'(t.tx);
   endfunction

endpackage

// File: rtl/tank_key_decode.sv
// Maps one player's keycode to a move request; PLAYER2 selects the arrow-key set.
module tank_key_decode
   import tank_pkg::*;
#(
   parameter bit PLAYER2 = 1'b0
) (
   input  logic [KEY_W-1:0] keycode,
   output move_req_t        req_c
);

   logic [KEY_W-1:0] key_up;
   logic [KEY_W-1:0] key_down;
   logic [KEY_W-1:0] key_left;
   logic [KEY_W-1:0] key_right;

   always_comb begin
      key_up    = PLAYER2 ? KEY2_UP    : KEY1_UP;
      key_down  = PLAYER2 ? KEY2_DOWN  : KEY1_DOWN;
      key_left  = PLAYER2 ? KEY2_LEFT  : KEY1_LEFT;
      key_right = PLAYER2 ? KEY2_RIGHT : KEY1_RIGHT;
      req_c     = '{valid: 1'b1, dir: DIR_UP};
      if (keycode == key_up) begin
         req_c.dir = DIR_UP;
      end else if (keycode == key_down) begin
         req_c.dir = DIR_DOWN;
      end else if (keycode == key_left) begin
         req_c.dir = DIR_LEFT;
      end else if (keycode == key_right) begin
         req_c.dir = DIR_RIGHT;
      end else begin
         req_c.valid = 1'b0;
      end
   end

endmodule

// File: rtl/tank_move_arbiter.sv
// Round-based arbiter: both tanks share one tile-map read port; walls, edges and the
// other tank block moves, and a per-player cooldown rate-limits granted moves.
module tank_move_arbiter
   import tank_pkg::*;
(
   input  logic              frame_clk,
   input  logic              Reset,
   input  logic [KEY_W-1:0]  keycode1,
   input  logic [KEY_W-1:0]  keycode2,
   output logic              map_rd_en,
   output logic [ADDR_W-1:0] map_addr,
   input  logic              map_wall,
   output logic [PIX_W-1:0]  tank1_x,
   output logic [PIX_W-1:0]  tank1_y,
   output logic [PIX_W-1:0]  tank2_x,
   output logic [PIX_W-1:0]  tank2_y,
   output logic              moved1,
   output logic              moved2,
   output logic              busy
);

   state_t          state_q, state_d;
   tile_t           p1_tile_q, p2_tile_q;
   logic [CD_W-1:0] p1_cd_q, p2_cd_q;
   logic            prio_q;

   logic            a_is_p2_q, a_elig_q, b_elig_q;
   target_t         a_tgt_q, b_tgt_q;
   logic            a_grant_q, b_grant_q;

   move_req_t       p1_req_c, p2_req_c;
   logic            p1_elig_c, p2_elig_c;
   target_t         p1_tgt_c, p2_tgt_c;
   logic            a_elig_c, b_elig_c;
   target_t         a_tgt_c, b_tgt_c;

   tile_t           a_tile_c, b_tile_c, b_other_c;
   tile_t           p1_new_c, p2_new_c;

   target_t           a_tgt_n, b_tgt_n;
   logic              a_grant_d, b_grant_d;
   logic              rd_en_d, moved1_d, moved2_d;
   logic [ADDR_W-1:0] addr_d;

   tank_key_decode #(.PLAYER2(1'b0)) u_key1 (
      .keycode (keycode1),
      .req_c   (p1_req_c)
   );

   tank_key_decode #(.PLAYER2(1'b1)) u_key2 (
      .keycode (keycode2),
      .req_c   (p2_req_c)
   );

   // Round set-up from live keys, only consumed while IDLE
   always_comb begin
      p1_elig_c = p1_req_c.valid && (p1_cd_q == '0);
      p2_elig_c = p2_req_c.valid && (p2_cd_q == '0);
      p1_tgt_c  = step_tile(p1_tile_q, p1_req_c.dir);
      p2_tgt_c  = step_tile(p2_tile_q, p2_req_c.dir);
      a_elig_c  = prio_q ? p2_elig_c : p1_elig_c;
      b_elig_c  = prio_q ? p1_elig_c : p2_elig_c;
      a_tgt_c   = prio_q ? p2_tgt_c  : p1_tgt_c;
      b_tgt_c   = prio_q ? p1_tgt_c  : p2_tgt_c;
   end

   // Tiles seen through the latched A/B roles; B must avoid A's granted target
   always_comb begin
      a_tile_c  = a_is_p2_q ? p2_tile_q : p1_tile_q;
      b_tile_c  = a_is_p2_q ? p1_tile_q : p2_tile_q;
      b_other_c = a_grant_q ? a_tgt_q.tile : a_tile_c;
      p1_new_c  = a_is_p2_q ? b_tgt_q.tile : a_tgt_q.tile;
      p2_new_c  = a_is_p2_q ? a_tgt_q.tile : b_tgt_q.tile;
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus next values of the registered read strobe and move pulses
   always_comb begin
      state_d   = state_q;
      a_grant_d = a_grant_q;
      b_grant_d = b_grant_q;
      rd_en_d   = 1'b0;
      addr_d    = map_addr;
      moved1_d  = 1'b0;
      moved2_d  = 1'b0;
      a_tgt_n   = (state_q == S_IDLE) ? a_tgt_c : a_tgt_q;
      b_tgt_n   = (state_q == S_IDLE) ? b_tgt_c : b_tgt_q;

      case (state_q)
         S_IDLE: begin
            a_grant_d = 1'b0;
            b_grant_d = 1'b0;
            if (a_elig_c) begin
               state_d = S_RD_A;
            end else if (b_elig_c) begin
               state_d = S_RD_B;
            end
         end
         S_RD_A: begin
            if (!a_tgt_q.off) begin
               state_d = S_CHK_A;
            end else begin
               state_d = b_elig_q ? S_RD_B : S_COMMIT;
            end
         end
         S_CHK_A: begin
            a_grant_d = !map_wall && (a_tgt_q.tile != b_tile_c);
            state_d   = b_elig_q ? S_RD_B : S_COMMIT;
         end
         S_RD_B: begin
            state_d = b_tgt_q.off ? S_COMMIT : S_CHK_B;
         end
         S_CHK_B: begin
            b_grant_d = !map_wall && (b_tgt_q.tile != b_other_c);
            state_d   = S_COMMIT;
         end
         S_COMMIT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if ((state_d == S_RD_A) && !a_tgt_n.off) begin
         rd_en_d = 1'b1;
         addr_d  = tile_index(a_tgt_n.tile);
      end else if ((state_d == S_RD_B) && !b_tgt_n.off) begin
         rd_en_d = 1'b1;
         addr_d  = tile_index(b_tgt_n.tile);
      end

      if (state_d == S_COMMIT) begin
         moved1_d = a_is_p2_q ? b_grant_d : a_grant_d;
         moved2_d = a_is_p2_q ? a_grant_d : b_grant_d;
      end
   end

   // Round latches, registered outputs, tiles, cooldowns and priority
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         busy      <= 1'b0;
         map_rd_en <= 1'b0;
         map_addr  <= '0;
         moved1    <= 1'b0;
         moved2    <= 1'b0;
         a_grant_q <= 1'b0;
         b_grant_q <= 1'b0;
         a_is_p2_q <= 1'b0;
         a_elig_q  <= 1'b0;
         b_elig_q  <= 1'b0;
         a_tgt_q   <= '0;
         b_tgt_q   <= '0;
         p1_tile_q <= P1_START;
         p2_tile_q <= P2_START;
         p1_cd_q   <= '0;
         p2_cd_q   <= '0;
         prio_q    <= 1'b0;
      end else begin
         busy      <= (state_d != S_IDLE);
         map_rd_en <= rd_en_d;
         map_addr  <= addr_d;
         moved1    <= moved1_d;
         moved2    <= moved2_d;
         a_grant_q <= a_grant_d;
         b_grant_q <= b_grant_d;

         if (state_q == S_IDLE) begin
            a_is_p2_q <= prio_q;
            a_elig_q  <= a_elig_c;
            b_elig_q  <= b_elig_c;
            a_tgt_q   <= a_tgt_c;
            b_tgt_q   <= b_tgt_c;
         end

         if ((state_q == S_COMMIT) && moved1) begin
            p1_cd_q <= CD_W'(MOVE_PERIOD - 1);
         end else if (p1_cd_q != '0) begin
            p1_cd_q <= p1_cd_q - CD_W'(1);
         end

         if ((state_q == S_COMMIT) && moved2) begin
            p2_cd_q <= CD_W'(MOVE_PERIOD - 1);
         end else if (p2_cd_q != '0) begin
            p2_cd_q <= p2_cd_q - CD_W'(1);
         end

         if (state_q == S_COMMIT) begin
            if (moved1) begin
               p1_tile_q <= p1_new_c;
            end
            if (moved2) begin
               p2_tile_q <= p2_new_c;
            end
            if (a_elig_q && b_elig_q) begin
               prio_q <= ~prio_q;
            end
         end
      end
   end

   assign tank1_x = PIX_W'(p1_tile_q.tx) << TILE_SHIFT;
   assign tank1_y = PIX_W'(p1_tile_q.ty) << TILE_SHIFT;
   assign tank2_x = PIX_W'(p2_tile_q.tx) << TILE_SHIFT;
   assign tank2_y = PIX_W'(p2_tile_q.ty) << TILE_SHIFT;

endmodule

// File: tb/tb_tank_move_arbiter.sv
// Self-checking bench: per-cycle comparison against a round-level model of the arbiter.
module tb_tank_move_arbiter;

   logic       frame_clk = 1'b0;
   logic       Reset     = 1'b0;
   logic [7:0] keycode1  = 8'h00;
   logic [7:0] keycode2  = 8'h00;
   logic       map_wall  = 1'b0;
   logic       map_rd_en;
   logic [8:0] map_addr;
   logic [9:0] tank1_x, tank1_y, tank2_x, tank2_y;
   logic       moved1, moved2, busy;

   tank_move_arbiter dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .keycode1  (keycode1),
      .keycode2  (keycode2),
      .map_rd_en (map_rd_en),
      .map_addr  (map_addr),
      .map_wall  (map_wall),
      .tank1_x   (tank1_x),
      .tank1_y   (tank1_y),
      .tank2_x   (tank2_x),
      .tank2_y   (tank2_y),
      .moved1    (moved1),
      .moved2    (moved2),
      .busy      (busy)
   );

   always #5 frame_clk = ~frame_clk;

   // Map RAM: wall bit appears the cycle after the read strobe
   bit wall_mem [512];
   always @(posedge frame_clk) begin
      if (map_rd_en) map_wall <= wall_mem[map_addr];
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected per-cycle view of one round cycle after IDLE
   typedef struct {
      bit rd;
      int addr;
      bit commit;
      bit mv1;
      bit mv2;
   } rec_t;

   rec_t q[$];
   rec_t cur;
   bit   in_round;
   int   m_tx[2], m_ty[2], m_cd[2];
   int   m_prio;
   bit   p_g[2];
   int   p_tx[2], p_ty[2];
   bit   p_tog;

   task automatic model_reset();
      m_tx[0] = 1;  m_ty[0] = 13;
      m_tx[1] = 18; m_ty[1] = 1;
      m_cd[0] = 0;  m_cd[1] = 0;
      m_prio  = 0;
      q.delete();
      in_round = 1'b0;
   endtask

   task automatic decode(input int p, input logic [7:0] k, output bit v, output int dx, output int dy);
      v = 1'b1; dx = 0; dy = 0;
      if (p == 0) begin
         case (k)
            8'h1A: dy = -1;
            8'h16: dy = 1;
            8'h04: dx = -1;
            8'h07: dx = 1;
            default: v = 1'b0;
         endcase
      end else begin
         case (k)
            8'h52: dy = -1;
            8'h51: dy = 1;
            8'h50: dx = -1;
            8'h4F: dx = 1;
            default: v = 1'b0;
         endcase
      end
   endtask

   // Resolve a whole round from the keys seen in IDLE and queue its expected cycles
   task automatic start_round();
      bit v[2];
      bit el[2];
      bit off[2];
      bit g[2];
      int dx[2], dy[2], tx[2], ty[2];
      int a, b, ox, oy;
      rec_t r;
      decode(0, keycode1, v[0], dx[0], dy[0]);
      decode(1, keycode2, v[1], dx[1], dy[1]);
      for (int p = 0; p < 2; p++) begin
         el[p]  = v[p] && (m_cd[p] == 0);
         tx[p]  = m_tx[p] + dx[p];
         ty[p]  = m_ty[p] + dy[p];
         off[p] = (tx[p] < 0) || (tx[p] >= 20) || (ty[p] < 0) || (ty[p] >= 15);
         g[p]   = 1'b0;
      end
      if (!el[0] && !el[1]) return;
      a = m_prio;
      b = 1 - m_prio;
      if (el[a]) begin
         if (off[a]) begin
            r = '{rd: 0, addr: 0, commit: 0, mv1: 0, mv2: 0}; q.push_back(r);
         end else begin
            r = '{rd: 1, addr: ty[a]*20 + tx[a], commit: 0, mv1: 0, mv2: 0}; q.push_back(r);
            r = '{rd: 0, addr: 0, commit: 0, mv1: 0, mv2: 0}; q.push_back(r);
            g[a] = !wall_mem[ty[a]*20 + tx[a]] && !((tx[a] == m_tx[b]) && (ty[a] == m_ty[b]));
         end
      end
      if (el[b]) begin
         ox = g[a] ? tx[a] : m_tx[a];
         oy = g[a] ? ty[a] : m_ty[a];
         if (off[b]) begin
            r = '{rd: 0, addr: 0, commit: 0, mv1: 0, mv2: 0}; q.push_back(r);
         end else begin
            r = '{rd: 1, addr: ty[b]*20 + tx[b], commit: 0, mv1: 0, mv2: 0}; q.push_back(r);
            r = '{rd: 0, addr: 0, commit: 0, mv1: 0, mv2: 0}; q.push_back(r);
            g[b] = !wall_mem[ty[b]*20 + tx[b]] && !((tx[b] == ox) && (ty[b] == oy));
         end
      end
      r = '{rd: 0, addr: 0, commit: 1, mv1: g[0], mv2: g[1]};
      q.push_back(r);
      for (int p = 0; p < 2; p++) begin
         p_g[p] = g[p]; p_tx[p] = tx[p]; p_ty[p] = ty[p];
      end
      p_tog = el[0] && el[1];
   endtask

   // One frame: drive keys, compare all outputs, then advance the model across the edge
   task automatic cycle(input logic [7:0] k1, input logic [7:0] k2);
      @(negedge frame_clk);
      keycode1 = k1;
      keycode2 = k2;
      check("busy",   32'(busy),      32'(in_round));
      check("rd_en",  32'(map_rd_en), 32'(in_round && cur.rd));
      if (in_round && cur.rd) check("map_addr", 32'(map_addr), 32'(cur.addr));
      check("moved1", 32'(moved1), 32'(in_round && cur.commit && cur.mv1));
      check("moved2", 32'(moved2), 32'(in_round && cur.commit && cur.mv2));
      check("tank1_x", 32'(tank1_x), 32'(m_tx[0] * 32));
      check("tank1_y", 32'(tank1_y), 32'(m_ty[0] * 32));
      check("tank2_x", 32'(tank2_x), 32'(m_tx[1] * 32));
      check("tank2_y", 32'(tank2_y), 32'(m_ty[1] * 32));
      if (!in_round) start_round();
      for (int p = 0; p < 2; p++) m_cd[p] = (m_cd[p] > 0) ? m_cd[p] - 1 : 0;
      if (in_round && cur.commit) begin
         for (int p = 0; p < 2; p++) begin
            if (p_g[p]) begin
               m_tx[p] = p_tx[p]; m_ty[p] = p_ty[p]; m_cd[p] = 7;
            end
         end
         if (p_tog) m_prio = 1 - m_prio;
      end
      if (q.size() > 0) begin
         cur = q.pop_front();
         in_round = 1'b1;
      end else begin
         in_round = 1'b0;
      end
   endtask

   // Asynchronous reset: outputs must return to reset values without waiting for a clock
   task automatic do_reset();
      keycode1 = 8'h00;
      keycode2 = 8'h00;
      Reset    = 1'b1;
      model_reset();
      #1;
      check("rst_busy",   32'(busy),      32'd0);
      check("rst_rd_en",  32'(map_rd_en), 32'd0);
      check("rst_addr",   32'(map_addr),  32'd0);
      check("rst_moved1", 32'(moved1),    32'd0);
      check("rst_moved2", 32'(moved2),    32'd0);
      check("rst_t1x", 32'(tank1_x), 32'd32);
      check("rst_t1y", 32'(tank1_y), 32'd416);
      check("rst_t2x", 32'(tank2_x), 32'd576);
      check("rst_t2y", 32'(tank2_y), 32'd32);
      @(negedge frame_clk);
      Reset = 1'b0;
   endtask

   logic [7:0] pool1 [6];
   logic [7:0] pool2 [6];
   logic [7:0] k1, k2;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pool1 = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h00, 8'h55};
      pool2 = '{8'h52, 8'h51, 8'h50, 8'h4F, 8'h00, 8'h1A};
      for (int i = 0; i < 512; i++) wall_mem[i] = 1'b0;
      #2;
      do_reset();

      // Idle frames: no keys, no lookups, tanks at start
      for (int i = 0; i < 20; i++) cycle(8'h00, 8'h00);

      // P1 holds right on an open map; first lookup is tile (2,13)
      cycle(8'h07, 8'h00);
      cycle(8'h07, 8'h00);
      check("first_addr", 32'(map_addr), 32'd262);
      for (int i = 0; i < 40; i++) cycle(8'h07, 8'h00);

      // P1 walks to (0,13) then pushes against the left edge
      do_reset();
      for (int i = 0; i < 40; i++) cycle(8'h04, 8'h00);
      check("edge_t1x", 32'(tank1_x), 32'd0);

      // P2 blocked by a wall at tile 39
      do_reset();
      wall_mem[39] = 1'b1;
      for (int i = 0; i < 12; i++) cycle(8'h00, 8'h4F);
      check("wall_t2x", 32'(tank2_x), 32'd576);
      wall_mem[39] = 1'b0;

      // Walk P1 to (5,5), then P2 to (7,5), one player at a time
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if (!in_round && m_tx[0] == 5 && m_ty[0] == 5 && m_tx[1] == 7 && m_ty[1] == 5) break;
         k1 = (m_tx[0] < 5) ? 8'h07 : ((m_ty[0] > 5) ? 8'h1A : 8'h00);
         k2 = 8'h00;
         if (m_tx[0] == 5 && m_ty[0] == 5)
            k2 = (m_tx[1] > 7) ? 8'h50 : ((m_ty[1] < 5) ? 8'h51 : 8'h00);
         cycle(k1, k2);
      end
      for (int i = 0; i < 10; i++) cycle(8'h00, 8'h00);
      check("nav_t1x", 32'(tank1_x), 32'd160);
      check("nav_t2x", 32'(tank2_x), 32'd224);

      // Contest for (6,5): P1 has priority and wins
      cycle(8'h07, 8'h50);
      for (int i = 0; i < 8; i++) cycle(8'h00, 8'h00);
      check("contest_t1x", 32'(tank1_x), 32'd192);
      check("contest_t2x", 32'(tank2_x), 32'd224);
      for (int i = 0; i < 10; i++) cycle(8'h00, 8'h00);

      // Next contest: P2 is looked up first, target (7,4)
      cycle(8'h1A, 8'h52);
      cycle(8'h00, 8'h00);
      check("prio_addr", 32'(map_addr), 32'd87);
      for (int i = 0; i < 10; i++) cycle(8'h00, 8'h00);

      // Randomized play on a random wall map, with occasional mid-round resets
      for (int i = 0; i < 300; i++) wall_mem[i] = ($urandom_range(0, 4) == 0);
      do_reset();
      k1 = 8'h00;
      k2 = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) k1 = pool1[$urandom_range(0, 5)];
         if ($urandom_range(0, 3) == 0) k2 = pool2[$urandom_range(0, 5)];
         cycle(k1, k2);
         if (in_round && $urandom_range(0, 150) == 0) begin
            do_reset();
            k1 = 8'h00;
            k2 = 8'h00;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
